// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: segment patterns, illegal nibble, frame FSM state encoding and digit index helper
package sevenseg_pkg;
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [3:0] ILLEGAL = 4'hF;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_COL1 = 2'd1;
    localparam state_t ST_COL2 = 2'd2;
    localparam state_t ST_COL3 = 2'd3;
    function automatic logic [1:0] digit_idx(input logic [3:0] sel);
        return sel[3] ? 2'd3 : sel[2] ? 2'd2 : sel[1] ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/sevenseg_bcd_digit_decode.sv
// sevenseg_bcd_digit_decode: maps one abcdefg pattern to its BCD nibble, flagging unknown patterns
module sevenseg_bcd_digit_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       illegal_o
);
    // No legal digit decodes to F, so the illegal flag falls out of the nibble itself
    always_comb begin
        nibble_o = ILLEGAL;
        case (seg_i)
            SEG_0: nibble_o = 4'd0;
            SEG_1: nibble_o = 4'd1;
            SEG_2: nibble_o = 4'd2;
            SEG_3: nibble_o = 4'd3;
            SEG_4: nibble_o = 4'd4;
            SEG_5: nibble_o = 4'd5;
            SEG_6: nibble_o = 4'd6;
            SEG_7: nibble_o = 4'd7;
            SEG_8: nibble_o = 4'd8;
            SEG_9: nibble_o = 4'd9;
            default: nibble_o = ILLEGAL;
        endcase
    end
    assign illegal_o = nibble_o == ILLEGAL;
endmodule

// File: rtl/sevenseg_bcd_scan_decoder.sv
// sevenseg_bcd_scan_decoder: debounces a scanned seven-segment display and assembles four-digit BCD frames
module sevenseg_bcd_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  dig_sel,
    input  logic [6:0]  seg,
    output logic [15:0] bcd_out,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        frame_abort
);
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
    logic [10:0] samp_q;
    logic [7:0]  cnt_q, cnt_d;
    state_t      state_q, state_d;
    logic [15:0] buf_q, buf_d, bcd_q;
    logic        err_q, err_d, done_q, done_d, abort_q, abort_d, valid_q, ferr_q;
    logic [3:0]  nib;
    logic [1:0]  idx;
    logic        ill, one_hot, same, capture, take;

    sevenseg_bcd_digit_decode u_dec (
        .seg_i     (seg),
        .nibble_o  (nib),
        .illegal_o (ill)
    );

    assign one_hot = $onehot(dig_sel);
    assign same    = {dig_sel, seg} == samp_q;
    assign idx     = digit_idx(dig_sel);
    // The saturated case keeps a 255-cycle threshold from firing again while the pattern is held
    assign capture = one_hot && cnt_d == STABLE && !(same && cnt_q == STABLE);
    // Digit 0 is always accepted: it either starts a frame or restarts an interrupted one
    assign take    = idx == state_q || idx == 2'd0;

    // Stability counter: cleared on a non-one-hot select, reloaded on change, saturating while held
    always_comb cnt_d = !one_hot ? 8'd0 : !same ? 8'd1 : cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;

    // Frame assembly; state value equals the digit index expected next, and COL3 wraps to IDLE
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        err_d   = err_q;
        done_d  = 1'b0;
        abort_d = capture && state_q != ST_IDLE && idx != state_q;
        if (capture && take) begin
            buf_d[{idx, 2'b00} +: 4] = nib;
            err_d   = (idx == 2'd0) ? ill : err_q | ill;
            state_d = idx + 2'd1;
            done_d  = idx == 2'd3;
        end else if (capture) begin
            state_d = ST_IDLE;
        end
    end

    // State registers; a completed frame is published one edge after its last capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            buf_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            valid_q <= 1'b0;
            bcd_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            samp_q  <= {dig_sel, seg};
            cnt_q   <= cnt_d;
            state_q <= state_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            valid_q <= done_q;
            if (done_q) begin
                bcd_q  <= buf_q;
                ferr_q <= err_q;
            end
        end
    end

    assign bcd_out     = bcd_q;
    assign frame_valid = valid_q;
    assign frame_err   = ferr_q;
    assign frame_abort = abort_q;
endmodule

// File: tb/tb_sevenseg_bcd_scan_decoder.sv
// tb_sevenseg_bcd_scan_decoder: directed scans with hand-computed frames, pulse counts and reset values
module tb_sevenseg_bcd_scan_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  dig_sel = 4'b0;
    logic [6:0]  seg = 7'b0;
    logic [15:0] bcd_out;
    logic        frame_valid, frame_err, frame_abort;
    int          errors = 0;
    int          checks = 0;
    int          nvalid = 0;
    int          nabort = 0;
    int          v0, a0;
    logic [6:0]  pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    sevenseg_bcd_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dig_sel     (dig_sel),
        .seg         (seg),
        .bcd_out     (bcd_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) nvalid++;
        if (frame_abort) nabort++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [3:0] s, input logic [6:0] g, input int n);
        dig_sel = s;
        seg = g;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int d0, input int d1, input int d2, input int d3, input int n);
        show(4'b0001, pat[d0], n);
        show(4'b0010, pat[d1], n);
        show(4'b0100, pat[d2], n);
        show(4'b1000, pat[d3], n);
        show(4'b0000, 7'b0, 3);
    endtask

    task automatic snap();
        v0 = nvalid;
        a0 = nabort;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_abort", 32'(frame_abort), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        snap();
        frame(4, 3, 2, 1, 6);
        check("t1_bcd", 32'(bcd_out), 32'h1234);
        check("t1_err", 32'(frame_err), 32'h0);
        check("t1_valid_cnt", 32'(nvalid - v0), 32'd1);
        check("t1_abort_cnt", 32'(nabort - a0), 32'd0);

        snap();
        show(4'b0001, pat[4], 6);
        show(4'b0010, pat[3], 6);
        show(4'b0100, 7'b1000000, 6);
        show(4'b1000, pat[1], 6);
        show(4'b0000, 7'b0, 3);
        check("t2_bcd", 32'(bcd_out), 32'h1F34);
        check("t2_err", 32'(frame_err), 32'h1);
        check("t2_valid_cnt", 32'(nvalid - v0), 32'd1);
        check("t2_abort_cnt", 32'(nabort - a0), 32'd0);

        snap();
        frame(9, 8, 7, 6, 20);
        check("t3_bcd", 32'(bcd_out), 32'h6789);
        check("t3_err", 32'(frame_err), 32'h0);
        check("t3_valid_cnt", 32'(nvalid - v0), 32'd1);
        check("t3_abort_cnt", 32'(nabort - a0), 32'd0);

        snap();
        show(4'b0001, pat[4], 6);
        show(4'b0010, pat[3], 3);
        show(4'b0100, pat[2], 6);
        show(4'b0000, 7'b0, 3);
        check("t4_bcd", 32'(bcd_out), 32'h6789);
        check("t4_valid_cnt", 32'(nvalid - v0), 32'd0);
        check("t4_abort_cnt", 32'(nabort - a0), 32'd1);

        snap();
        show(4'b0001, pat[0], 6);
        show(4'b0011, pat[7], 10);
        show(4'b0000, pat[7], 10);
        check("t5_quiet_valid", 32'(nvalid - v0), 32'd0);
        show(4'b0010, pat[2], 6);
        show(4'b0100, pat[4], 6);
        show(4'b1000, pat[8], 6);
        show(4'b0000, 7'b0, 3);
        check("t5_bcd", 32'(bcd_out), 32'h8420);
        check("t5_valid_cnt", 32'(nvalid - v0), 32'd1);
        check("t5_abort_cnt", 32'(nabort - a0), 32'd0);

        snap();
        show(4'b0001, pat[5], 6);
        show(4'b0010, pat[5], 6);
        rst_n = 1'b0;
        dig_sel = 4'b0;
        seg = 7'b0;
        #1;
        check("t6_rst_bcd", 32'(bcd_out), 32'h0);
        check("t6_rst_valid", 32'(frame_valid), 32'h0);
        check("t6_rst_err", 32'(frame_err), 32'h0);
        check("t6_rst_abort", 32'(frame_abort), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(5, 5, 5, 5, 6);
        check("t6_bcd", 32'(bcd_out), 32'h5555);
        check("t6_valid_cnt", 32'(nvalid - v0), 32'd1);
        check("t6_abort_cnt", 32'(nabort - a0), 32'd0);

        snap();
        show(4'b0100, pat[1], 6);
        show(4'b1000, pat[1], 6);
        show(4'b0000, 7'b0, 3);
        check("t7_bcd", 32'(bcd_out), 32'h5555);
        check("t7_valid_cnt", 32'(nvalid - v0), 32'd0);
        check("t7_abort_cnt", 32'(nabort - a0), 32'd0);

        snap();
        frame(1, 2, 3, 4, 4);
        check("t8_bcd", 32'(bcd_out), 32'h4321);
        check("t8_valid_cnt", 32'(nvalid - v0), 32'd1);
        check("t8_abort_cnt", 32'(nabort - a0), 32'd0);

        snap();
        show(4'b0001, pat[1], 6);
        show(4'b0010, pat[1], 6);
        show(4'b0001, pat[7], 6);
        show(4'b0010, pat[3], 6);
        show(4'b0100, pat[0], 6);
        show(4'b1000, pat[9], 6);
        show(4'b0000, 7'b0, 3);
        check("t9_bcd", 32'(bcd_out), 32'h9037);
        check("t9_valid_cnt", 32'(nvalid - v0), 32'd1);
        check("t9_abort_cnt", 32'(nabort - a0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sevenseg_bcd_scan_decoder.md
SEVENSEG_BCD_SCAN_DECODER -- requirements
Module: sevenseg_bcd_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive clock edges a digit pattern must be held before capture; legal range 1..255.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 dig_sel  input  4  one-hot digit enable of the scanned display; bit 0 = least significant digit.
REQ-005 seg  input  7  segment lines, active-high, seg[6:0] = {a,b,c,d,e,f,g}.
REQ-006 bcd_out  output  16  last completed frame, four BCD nibbles, [3:0] = digit 0.
REQ-007 frame_valid  output  1  one-cycle pulse, bcd_out/frame_err updated this cycle.
REQ-008 frame_err  output  1  at least one illegal pattern in the frame reported with frame_valid.
REQ-009 frame_abort  output  1  one-cycle pulse, partial frame discarded due to out-of-order digit.

Function
REQ-010 Decode table (abcdefg -> value): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9; any other pattern SHALL decode to nibble 4'hF and mark illegal.
REQ-011 dig_sel not exactly one-hot (zero or multiple bits) SHALL be ignored: no capture, stability counter cleared.
REQ-012 Stability: registered copy of {dig_sel,seg}; counter increments (saturating) when the current sample equals the previous one, reloads to 1 on any change.
REQ-013 Capture strobe SHALL fire exactly once per held pattern, on the edge where the same one-hot pattern has been sampled on STABLE_CYCLES consecutive edges; no re-capture until the pattern changes.
REQ-014 Frame FSM states: IDLE (expect digit 0), COLLECT(n) for n=1..3 (expect digit n).
REQ-015 IDLE: capture of digit 0 stores nibble 0, clears error accumulator (then ORs its illegal flag), goes COLLECT(1); capture of digits 1..3 ignored, no abort.
REQ-016 COLLECT(n): capture of digit n stores nibble n, ORs illegal flag, advances to COLLECT(n+1); for n=3, goes IDLE and completes the frame.
REQ-017 COLLECT(n): capture of any other digit pulses frame_abort next cycle; if that digit is 0 the FSM restarts the frame as in REQ-015, otherwise goes IDLE.
REQ-018 Latency: bcd_out, frame_err and frame_valid SHALL update on the edge after the digit-3 capture edge; bcd_out/frame_err hold until next completed frame.
REQ-019 Partial frames SHALL never alter bcd_out.

Reset
REQ-020 While rst_n low: bcd_out=16'h0000, frame_valid=0, frame_err=0, frame_abort=0, FSM=IDLE, stability counter=0, sample register=0.
REQ-021 Reset mid-frame SHALL discard the partial frame with no frame_abort pulse; first capture after release follows REQ-015.

Structure
REQ-022 Shared package sevenseg_pkg SHALL hold the ten segment pattern constants, the ILLEGAL nibble constant 4'hF and the FSM state typedef.
REQ-023 Combinational sub-module sevenseg_bcd_digit_decode (seg in; nibble, illegal out) SHALL implement REQ-010; all sequential logic in the top.

Verification
REQ-024 Scan 1,2,3,4 on digits 3..0 in order 0..3, each held 6 cycles, STABLE_CYCLES=4 -> one frame_valid, bcd_out=16'h1234, frame_err=0.
REQ-025 Digit 2 shows 1000000 -> frame_valid with bcd_out=16'h?F?? (nibble 2 = F), frame_err=1.
REQ-026 Digit 1 held only 3 cycles (STABLE_CYCLES=4) then digit 2 -> no capture of digit 1, frame_abort pulse on digit-2 capture, bcd_out unchanged.
REQ-027 dig_sel=4'b0011 held 10 cycles with valid seg -> no capture, no pulses; dig_sel=0 likewise.
REQ-028 Pattern held 20 cycles -> exactly one capture; frame of 9,8,7,6 completes with bcd_out=16'h6789 and single frame_valid.
REQ-029 rst_n low for 1 cycle after digit 1 captured, then full scan 5,5,5,5 -> no frame_abort, bcd_out=16'h5555, reset values checked during rst_n low.
